csr_trap_ctrl: RTL and testbench
================================

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

Interface
REQ-001 SHALL have parameter ECALL_CAUSE, default 32'd11, the value written to MCAUSE on ECALL.
REQ-002 SHALL have parameter ADDR_MEPC, default 12'h341, the MEPC CSR address.
REQ-003 SHALL have parameter ADDR_MCAUSE, default 12'h342, the MCAUSE CSR address.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports valid_i (input, 1) and ready_o (output, 1): the request handshake.
REQ-007 SHALL have port op_i, input, 3 bits: 0=CSRRW, 1=CSRRS, 2=CSRRC, 3=ECALL, 4=MRET, 5-7 illegal.
REQ-008 SHALL have ports pc_i (input, 32), csr_addr_i (input, 12) and rs1_data_i (input, 32): request operands.
REQ-009 SHALL have ports csr_we_o (output, 1), csr_waddr_o (output, 12) and csr_wdata_o (output, 32): the CSR-file write port.
REQ-010 SHALL have ports csr_raddr_o (output, 12) and csr_rdata_i (input, 32): the CSR-file combinational read port.
REQ-011 SHALL have ports csr_mtvec_i and csr_mepc_i (input, 32 each): current MTVEC and MEPC values.
REQ-012 SHALL have ports done_o (output, 1) and rd_data_o (output, 32): completion pulse and old CSR value.
REQ-013 SHALL have ports redirect_o (output, 1) and redirect_pc_o (output, 32): fetch redirect request and target.

Function
REQ-014 SHALL implement states IDLE, ACCESS, TRAP_EPC, TRAP_CAUSE, TRAP_JMP and RET.
REQ-015 SHALL drive ready_o=1 only in IDLE; a request is accepted when valid_i&&ready_o at a rising edge.
REQ-016 SHALL latch op_i, pc_i, csr_addr_i and rs1_data_i on acceptance and hold them until return to IDLE.
REQ-017 SHALL transition on acceptance: ops 0-2 and 5-7 go to ACCESS, ECALL goes to TRAP_EPC, MRET goes to RET.
REQ-018 SHALL in ACCESS drive csr_raddr_o=latched addr and rd_data_o=csr_rdata_i, then go to IDLE.
REQ-019 SHALL in ACCESS write new = CSRRW: rs1; CSRRS: old|rs1; CSRRC: old&~rs1, with old = csr_rdata_i.
REQ-020 SHALL in ACCESS drive csr_we_o=1 and csr_waddr_o=latched addr.
REQ-021 SHALL suppress the ACCESS write (csr_we_o=0) for CSRRS/CSRRC when latched rs1=0.
REQ-022 SHALL treat illegal ops in ACCESS as a no-op: csr_we_o=0, rd_data_o=0, done_o=1, no redirect.
REQ-023 SHALL in TRAP_EPC drive csr_we_o=1, csr_waddr_o=ADDR_MEPC and csr_wdata_o=latched pc, then go to TRAP_CAUSE.
REQ-024 SHALL in TRAP_CAUSE drive csr_we_o=1, csr_waddr_o=ADDR_MCAUSE and csr_wdata_o=ECALL_CAUSE, then go to TRAP_JMP.
REQ-025 SHALL in TRAP_JMP drive redirect_o=1, redirect_pc_o=csr_mtvec_i and done_o=1, then go to IDLE.
REQ-026 SHALL in RET drive redirect_o=1, redirect_pc_o=csr_mepc_i and done_o=1, with no CSR write, then go to IDLE.
REQ-027 SHALL drive done_o high exactly 1 cycle per accepted request: in ACCESS, TRAP_JMP or RET.
REQ-028 SHALL have latency from acceptance edge to done_o of 1 cycle for CSR ops, illegal ops and MRET, and 3 cycles for ECALL.
REQ-029 SHALL issue at most one CSR write per cycle; csr_we_o=0 in IDLE, TRAP_JMP and RET.
REQ-030 SHALL drive csr_waddr_o, csr_wdata_o, csr_raddr_o, redirect_pc_o and rd_data_o to 0 whenever their enable/done is low.
REQ-031 SHALL ignore valid_i outside IDLE; a back-to-back request is accepted on the done_o cycle's following edge (IDLE).
REQ-032 SHALL NOT flag an access to an unimplemented CSR address; it reads 0 and the write is dropped by the CSR file.

Reset
REQ-033 SHALL enter IDLE immediately on rst_n_i low, independent of clk_i.
REQ-034 SHALL hold, while in reset, csr_we_o=0, done_o=0, redirect_o=0, all data/address outputs 0 and ready_o=1, and SHALL accept no request.
REQ-035 SHALL abandon any sequence in progress when reset asserts mid-operation, issuing no further writes or redirects.

Verification
REQ-036 SHALL pass: CSRRW addr 0x305, rs1=0x80000000, old=0x0 -> next cycle we=1, waddr=0x305, wdata=0x80000000, rd_data=0, done=1.
REQ-037 SHALL pass: CSRRS addr 0x300, rs1=0, old=0x1800 -> we=0, rd_data=0x1800, done=1; with rs1=0x8 -> wdata=0x1808.
REQ-038 SHALL pass: ECALL pc=0x80000010, mtvec=0x80000100 -> MEPC write 0x80000010, then MCAUSE write 11, then redirect to 0x80000100 with done; ready_o=0 for 3 cycles.
REQ-039 SHALL pass: MRET with mepc=0x80000014 -> 1 cycle later redirect_o=1, redirect_pc_o=0x80000014, done=1, we=0.
REQ-040 SHALL pass: reset asserted in TRAP_CAUSE -> no MCAUSE write, no redirect, IDLE with ready_o=1 after release.
REQ-041 SHALL pass: op=7 -> done=1 after 1 cycle, rd_data=0, we=0, redirect=0; valid_i held during busy cycles is not re-accepted.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// ----------------------------------------------------------------------------
// csr_trap_ctrl
//
// Sequencer for the machine-mode CSR instructions and the ECALL/MRET trap
// flow. A request (op, pc, csr address, rs1 value) is accepted in IDLE and
// its operands are held until the sequence returns to IDLE.
//   CSRRW/CSRRS/CSRRC : one ACCESS cycle (read old value, write new value)
//   ECALL             : MEPC write, MCAUSE write, then redirect to MTVEC
//   MRET              : redirect to MEPC
//   op 5-7            : one ACCESS cycle that completes with no side effect
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   valid_i / ready_o       request handshake (ready only in IDLE)
//   op_i, pc_i, csr_addr_i, rs1_data_i   request operands
//   csr_we_o, csr_waddr_o, csr_wdata_o   CSR-file write port
//   csr_raddr_o, csr_rdata_i             CSR-file combinational read port
//   csr_mtvec_i, csr_mepc_i              current MTVEC / MEPC values
//   done_o, rd_data_o                    completion pulse and old CSR value
//   redirect_o, redirect_pc_o            fetch redirect request and target
// All data/address outputs are zero whenever their enable/done is low.
// ----------------------------------------------------------------------------
module csr_trap_ctrl #(
    parameter logic [31:0] ECALL_CAUSE = 32'd11,
    parameter logic [11:0] ADDR_MEPC   = 12'h341,
    parameter logic [11:0] ADDR_MCAUSE = 12'h342
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  op_i,
    input  logic [31:0] pc_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] rs1_data_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic [11:0] csr_raddr_o,
    input  logic [31:0] csr_rdata_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    output logic        done_o,
    output logic [31:0] rd_data_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        TRAP_EPC,
        TRAP_CAUSE,
        TRAP_JMP,
        RET
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  op_reg;
    logic [31:0] pc_reg;
    logic [11:0] addr_reg;
    logic [31:0] rs1_reg;
    logic [31:0] new_val;
    logic        access_we;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture on acceptance; held for the whole sequence
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_reg   <= 3'd0;
            pc_reg   <= 32'd0;
            addr_reg <= 12'd0;
            rs1_reg  <= 32'd0;
        end else if (state_reg == IDLE && valid_i) begin
            op_reg   <= op_i;
            pc_reg   <= pc_i;
            addr_reg <= csr_addr_i;
            rs1_reg  <= rs1_data_i;
        end
    end

    // Read-modify-write value for the CSR instructions
    always_comb begin
        new_val   = 32'd0;
        access_we = 1'b0;
        case (op_reg)
            OP_CSRRW: begin
                new_val   = rs1_reg;
                access_we = 1'b1;
            end
            OP_CSRRS: begin
                new_val   = csr_rdata_i | rs1_reg;
                access_we = (rs1_reg != 32'd0);   // set with zero mask: read only
            end
            OP_CSRRC: begin
                new_val   = csr_rdata_i & ~rs1_reg;
                access_we = (rs1_reg != 32'd0);   // clear with zero mask: read only
            end
            default: begin
                new_val   = 32'd0;
                access_we = 1'b0;
            end
        endcase
    end

    // Next state and outputs
    always_comb begin
        state_next    = state_reg;
        ready_o       = 1'b0;
        csr_we_o      = 1'b0;
        csr_waddr_o   = 12'd0;
        csr_wdata_o   = 32'd0;
        csr_raddr_o   = 12'd0;
        done_o        = 1'b0;
        rd_data_o     = 32'd0;
        redirect_o    = 1'b0;
        redirect_pc_o = 32'd0;

        case (state_reg)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    case (op_i)
                        OP_ECALL: state_next = TRAP_EPC;
                        OP_MRET:  state_next = RET;
                        default:  state_next = ACCESS;  // CSR ops and illegal ops
                    endcase
                end
            end
            ACCESS: begin
                done_o     = 1'b1;
                state_next = IDLE;
                // Illegal ops reach ACCESS too but leave every output at zero
                if (op_reg == OP_CSRRW || op_reg == OP_CSRRS || op_reg == OP_CSRRC) begin
                    csr_raddr_o = addr_reg;
                    rd_data_o   = csr_rdata_i;
                    if (access_we) begin
                        csr_we_o    = 1'b1;
                        csr_waddr_o = addr_reg;
                        csr_wdata_o = new_val;
                    end
                end
            end
            TRAP_EPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = pc_reg;
                state_next  = TRAP_CAUSE;
            end
            TRAP_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = ECALL_CAUSE;
                state_next  = TRAP_JMP;
            end
            TRAP_JMP: begin
                redirect_o    = 1'b1;
                redirect_pc_o = csr_mtvec_i;
                done_o        = 1'b1;
                state_next    = IDLE;
            end
            RET: begin
                redirect_o    = 1'b1;
                redirect_pc_o = csr_mepc_i;
                done_o        = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_csr_trap_ctrl
//
// Each request pushes the per-cycle output records it should produce into a
// queue; the records are popped and compared on the falling edge of each
// following cycle. A simple CSR-file read model answers csr_raddr_o.
// ----------------------------------------------------------------------------
module tb_csr_trap_ctrl;

    typedef struct packed {
        logic        ready;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] rd_data;
        logic        done;
        logic        redirect;
        logic [31:0] redirect_pc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] pc_i = 32'd0;
    logic [11:0] csr_addr_i = 12'd0;
    logic [31:0] rs1_data_i = 32'd0;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic [11:0] csr_raddr_o;
    logic [31:0] csr_rdata_i;
    logic [31:0] csr_mtvec_i = 32'd0;
    logic [31:0] csr_mepc_i = 32'd0;
    logic        done_o;
    logic [31:0] rd_data_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;

    logic [11:0] cur_addr = 12'h000;
    logic [31:0] cur_old = 32'd0;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    // One CSR holds cur_old; every other address reads as zero
    assign csr_rdata_i = (csr_raddr_o == cur_addr) ? cur_old : 32'd0;

    csr_trap_ctrl dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .op_i         (op_i),
        .pc_i         (pc_i),
        .csr_addr_i   (csr_addr_i),
        .rs1_data_i   (rs1_data_i),
        .csr_we_o     (csr_we_o),
        .csr_waddr_o  (csr_waddr_o),
        .csr_wdata_o  (csr_wdata_o),
        .csr_raddr_o  (csr_raddr_o),
        .csr_rdata_i  (csr_rdata_i),
        .csr_mtvec_i  (csr_mtvec_i),
        .csr_mepc_i   (csr_mepc_i),
        .done_o       (done_o),
        .rd_data_o    (rd_data_o),
        .redirect_o   (redirect_o),
        .redirect_pc_o(redirect_pc_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic compare_rec(input string name, input exp_t e);
        check({name, ".ready"},       {31'd0, ready_o},       {31'd0, e.ready});
        check({name, ".we"},          {31'd0, csr_we_o},      {31'd0, e.we});
        check({name, ".waddr"},       {20'd0, csr_waddr_o},   {20'd0, e.waddr});
        check({name, ".wdata"},       csr_wdata_o,            e.wdata);
        check({name, ".raddr"},       {20'd0, csr_raddr_o},   {20'd0, e.raddr});
        check({name, ".rd_data"},     rd_data_o,              e.rd_data);
        check({name, ".done"},        {31'd0, done_o},        {31'd0, e.done});
        check({name, ".redirect"},    {31'd0, redirect_o},    {31'd0, e.redirect});
        check({name, ".redirect_pc"}, redirect_pc_o,          e.redirect_pc);
    endtask

    function automatic exp_t idle_rec();
        exp_t e;
        e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    // Reference model: records for every cycle following acceptance
    task automatic push_expected(input logic [2:0] op, input logic [31:0] pc,
                                 input logic [11:0] addr, input logic [31:0] rs1,
                                 input logic [31:0] old, input logic [31:0] mtvec,
                                 input logic [31:0] mepc);
        exp_t e;
        e = '0;
        case (op)
            3'd0, 3'd1, 3'd2: begin
                e.raddr   = addr;
                e.rd_data = old;
                e.done    = 1'b1;
                if (op == 3'd0 || rs1 != 32'd0) begin
                    e.we    = 1'b1;
                    e.waddr = addr;
                    e.wdata = (op == 3'd0) ? rs1 : (op == 3'd1) ? (old | rs1) : (old & ~rs1);
                end
                exp_q.push_back(e);
            end
            3'd3: begin
                e.we = 1'b1; e.waddr = 12'h341; e.wdata = pc;
                exp_q.push_back(e);
                e.waddr = 12'h342; e.wdata = 32'd11;
                exp_q.push_back(e);
                e = '0;
                e.redirect = 1'b1; e.redirect_pc = mtvec; e.done = 1'b1;
                exp_q.push_back(e);
            end
            3'd4: begin
                e.redirect = 1'b1; e.redirect_pc = mepc; e.done = 1'b1;
                exp_q.push_back(e);
            end
            default: begin
                e.done = 1'b1;
                exp_q.push_back(e);
            end
        endcase
        exp_q.push_back(idle_rec());
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge
    task automatic do_req(input logic [2:0] op, input logic [31:0] pc,
                          input logic [11:0] addr, input logic [31:0] rs1,
                          input logic [31:0] old, input logic [31:0] mtvec,
                          input logic [31:0] mepc, input bit hold);
        exp_t e;
        string name;
        name = $sformatf("op%0d_%03h", op, addr);
        check({name, ".accept_ready"}, {31'd0, ready_o}, 32'd1);
        cur_addr    = addr;
        cur_old     = old;
        csr_mtvec_i = mtvec;
        csr_mepc_i  = mepc;
        op_i        = op;
        pc_i        = pc;
        csr_addr_i  = addr;
        rs1_data_i  = rs1;
        valid_i     = 1'b1;
        push_expected(op, pc, addr, rs1, old, mtvec, mepc);
        @(posedge clk_i);
        #1;
        if (!hold) begin
            // Scramble operands to prove they were captured at acceptance
            valid_i    = 1'b0;
            op_i       = 3'($urandom_range(0, 7));
            pc_i       = $urandom;
            csr_addr_i = 12'($urandom);
            rs1_data_i = $urandom;
        end
        while (exp_q.size() > 0) begin
            @(negedge clk_i);
            e = exp_q.pop_front();
            compare_rec(name, e);
            if (e.done) valid_i = 1'b0;
        end
        $display("req op=%0d addr=0x%03h rs1=0x%08h old=0x%08h hold=%0d checked",
                 op, addr, rs1, old, hold);
    endtask

    initial begin
        exp_t e;
        // Reset held with a pending request: nothing may be accepted
        op_i = 3'd3; valid_i = 1'b1; pc_i = 32'h1234_5678;
        repeat (3) begin
            @(negedge clk_i);
            compare_rec("in_reset", idle_rec());
        end
        valid_i = 1'b0;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        compare_rec("after_reset", idle_rec());

        do_req(3'd0, 32'h0, 12'h305, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 1'b0);
        do_req(3'd1, 32'h0, 12'h300, 32'h0, 32'h0000_1800, 32'h0, 32'h0, 1'b0);
        do_req(3'd1, 32'h0, 12'h300, 32'h8, 32'h0000_1800, 32'h0, 32'h0, 1'b0);
        do_req(3'd2, 32'h0, 12'h300, 32'h8, 32'h0000_1808, 32'h0, 32'h0, 1'b0);
        do_req(3'd2, 32'h0, 12'h300, 32'h0, 32'h0000_1808, 32'h0, 32'h0, 1'b0);
        do_req(3'd3, 32'h8000_0010, 12'h000, 32'h0, 32'h0, 32'h8000_0100, 32'h0, 1'b0);
        do_req(3'd3, 32'h8000_0040, 12'h000, 32'h0, 32'h0, 32'h8000_0200, 32'h0, 1'b1);
        do_req(3'd4, 32'h0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h8000_0014, 1'b0);
        do_req(3'd7, 32'h0, 12'h305, 32'hffff_ffff, 32'hdead_beef, 32'h0, 32'h0, 1'b1);
        do_req(3'd5, 32'h0, 12'h341, 32'h1, 32'h0000_0042, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_req(3'(i % 3), 32'h0, 12'h340 + 12'(i), $urandom, $urandom,
                   32'h0, 32'h0, 1'b0);
        end

        // Reset asserted while in TRAP_CAUSE abandons the trap
        op_i = 3'd3; pc_i = 32'h8000_0020; csr_mtvec_i = 32'h8000_0100; valid_i = 1'b1;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        @(negedge clk_i);
        e = '0; e.we = 1'b1; e.waddr = 12'h341; e.wdata = 32'h8000_0020;
        compare_rec("rst_epc", e);
        @(posedge clk_i);
        #1 rst_n_i = 1'b0;
        #1 compare_rec("rst_cause", idle_rec());
        @(negedge clk_i);
        compare_rec("rst_hold", idle_rec());
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(idle_rec());
        end
        while (exp_q.size() > 0) begin
            @(negedge clk_i);
            compare_rec("rst_after", exp_q.pop_front());
        end
        $display("req reset-in-trap sequence checked");

        do_req(3'd4, 32'h0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h8000_0080, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
